// File: rtl/sev_scan_ctrl.sv
// sev_scan_ctrl -- time-multiplexed scan controller for an N-digit
// common-anode 7-segment display.
//
// Lights one digit at a time. Each digit slot is GAP_CYC dark cycles followed
// by SLOT_CYC-GAP_CYC lit cycles. Values written through load/data_in are held
// in a shadow register and reach the display register only at a frame boundary
// or while the scanner is off, so a frame never mixes old and new digits.
//
// Optional feature macro: SEV_SCAN_LZ_BLANK_EN (leading-zero blanking).
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   en           in   1 = scanning, 0 = display dark
//   load         in   1-cycle strobe, captures data_in
//   data_in      in   4*N_DIGITS packed nibbles, digit 0 = [3:0] (rightmost)
//   an           out  anode enables, active-low, one-hot-low or all-high
//   seg          out  segments a..g (MSB = a), active-low
//   frame_tick   out  pulse on the last cycle of digit N_DIGITS-1's slot

// Hex nibble to active-low a..g segment pattern (MSB = a).
module sev_decoder (
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h7F;
    case (nib_i)
      4'h0: seg_o = 7'b0000001;
      4'h1: seg_o = 7'b1001111;
      4'h2: seg_o = 7'b0010010;
      4'h3: seg_o = 7'b0000110;
      4'h4: seg_o = 7'b1001100;
      4'h5: seg_o = 7'b0100100;
      4'h6: seg_o = 7'b0100000;
      4'h7: seg_o = 7'b0001111;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0000100;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b1100000;
      4'hC: seg_o = 7'b0110001;
      4'hD: seg_o = 7'b1000010;
      4'hE: seg_o = 7'b0110000;
      4'hF: seg_o = 7'b0111000;
      default: seg_o = 7'h7F;
    endcase
  end
endmodule

module sev_scan_ctrl #(
  parameter int N_DIGITS = 4,
  parameter int SLOT_CYC = 50000,
  parameter int GAP_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   data_in,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    frame_tick
);
  localparam int CW = $clog2(SLOT_CYC);
  localparam int IW = $clog2(N_DIGITS);
  localparam int DW = 4 * N_DIGITS;

  typedef enum logic [1:0] {S_OFF, S_GAP, S_ON} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q,   idx_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic [DW-1:0]   display_q, display_d;
  logic            pending_q, pending_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            tick_q, tick_d;

  logic            boundary;
  logic            xfer;
  logic [3:0]      nib;
  logic [6:0]      dec_seg;
  logic            blank;

  assign boundary = (state_q == S_ON) && (idx_q == IW'(N_DIGITS-1)) &&
                    (cnt_q == CW'(SLOT_CYC-1));
  assign xfer     = (state_q == S_OFF) || boundary;

  // Scan FSM next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_OFF: begin
        if (en) begin
          state_d = S_GAP;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(GAP_CYC-1)) state_d = S_ON;
      end
      S_ON: begin
        if (cnt_q == CW'(SLOT_CYC-1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
          idx_d   = (idx_q == IW'(N_DIGITS-1)) ? '0 : idx_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_OFF;
    endcase
    if (!en) begin
      state_d = S_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  // Shadow/display double buffer. shadow_d already holds a same-cycle load,
  // so a load coinciding with a transfer goes straight to the display.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    display_d = display_q;
    if (load) begin
      shadow_d  = data_in;
      pending_d = 1'b1;
    end
    if (xfer && pending_d) begin
      display_d = shadow_d;
      pending_d = 1'b0;
    end
  end

  // Outputs are computed from next-state values so the registered an/seg
  // line up with the registered FSM state.
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < N_DIGITS; i++)
      if (idx_d == IW'(i)) nib = display_d[i*4 +: 4];
  end

  sev_decoder u_dec (.nib_i(nib), .seg_o(dec_seg));

`ifdef SEV_SCAN_LZ_BLANK_EN
  // zero_from[i]: nibbles i..N_DIGITS-1 are all zero. Taken from the
  // display value, so blanking only changes at frame boundaries.
  logic [N_DIGITS-1:0] zero_from;
  always_comb begin
    zero_from = '0;
    zero_from[N_DIGITS-1] = (display_d[DW-1 -: 4] == 4'h0);
    for (int i = N_DIGITS-2; i >= 0; i--)
      zero_from[i] = zero_from[i+1] && (display_d[i*4 +: 4] == 4'h0);
    blank = 1'b0;
    for (int i = 1; i < N_DIGITS; i++)
      if (idx_d == IW'(i)) blank = zero_from[i];
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    if (state_d == S_ON) begin
      for (int i = 0; i < N_DIGITS; i++)
        if (idx_d == IW'(i)) an_d[i] = 1'b0;
      seg_d = blank ? 7'h7F : dec_seg;
    end
    tick_d = (state_d == S_ON) && (idx_d == IW'(N_DIGITS-1)) &&
             (cnt_d == CW'(SLOT_CYC-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_OFF;
      idx_q     <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      display_q <= '0;
      pending_q <= 1'b0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      display_q <= display_d;
      pending_q <= pending_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      tick_q    <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule
